hazard_fwd_unit: RTL and testbench

- Parametrised hazard and forwarding controller for the next generation of the 5-stage RV32 pipeline.
- Adds the RAW forwarding, load-use stall and taken-branch flush that the current pipeline lacks.
- Tracks in-flight register writers in an internal scoreboard that mirrors the post-ID stages.
- Drives PC/IF-ID hold, ID/EX bubble insertion and IF/ID flush. Publishes registered EX operand-forward selects and saturating stall/flush counters.
- Write-back-slot hazards are covered by the write-first register file and are not tracked here.

---
 rtl/hazard_fwd_unit.sv | 122 ++++++++++++
 tb/tb_hazard_fwd_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage RV32 pipeline.
// A shadow scoreboard tracks the register writers that sit in the post-ID stages.
// From it the block derives the EX operand-forward selects, the load-use stall and
// the taken-branch flush.
module hazard_fwd_unit #(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned NFWD       = 2,
   parameter int unsigned LOAD_STAGE = 2,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned SEL_W      = $clog2(NFWD + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              ex_redirect,
   output logic              stall_if,
   output logic              bubble_ex,
   output logic              flush_if_id,
   output logic [SEL_W-1:0]  ex_fwd_a_sel,
   output logic [SEL_W-1:0]  ex_fwd_b_sel,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   // Scoreboard slot k mirrors the pipeline register after stage k (1 = EX, 2 = MEM, ...)
   logic [NFWD:1]     slot_valid;
   logic [NFWD:1]     slot_rw;
   logic [NFWD:1]     slot_mr;
   logic [REG_AW-1:0] slot_rd [1:NFWD];

   logic [SEL_W-1:0]  prod_a;
   logic [SEL_W-1:0]  prod_b;
   logic              lu_a;
   logic              lu_b;
   logic              stall_raw;

   // Producer search: scan oldest to youngest so the youngest match is the one that remains
   always_comb begin
      prod_a = '0;
      prod_b = '0;
      lu_a   = 1'b0;
      lu_b   = 1'b0;
      for (int unsigned j = NFWD; j >= 1; j--) begin
         if (id_valid && id_use_rs1 && id_rs1 != '0 &&
             slot_valid[j] && slot_rw[j] && slot_rd[j] == id_rs1) begin
            prod_a = SEL_W'(j);
            lu_a   = slot_mr[j] && (j < LOAD_STAGE);
         end
         if (id_valid && id_use_rs2 && id_rs2 != '0 &&
             slot_valid[j] && slot_rw[j] && slot_rd[j] == id_rs2) begin
            prod_b = SEL_W'(j);
            lu_b   = slot_mr[j] && (j < LOAD_STAGE);
         end
      end
      stall_raw = lu_a || lu_b;
   end

   // Pipeline control: a redirect overrides a load-use stall; all controls are quiet in reset
   always_comb begin
      stall_if    = 1'b0;
      bubble_ex   = 1'b0;
      flush_if_id = 1'b0;
      if (!reset) begin
         if (ex_redirect) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
         end else if (stall_raw) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
         end
      end
   end

   // Scoreboard shift, forward-select registers and saturating event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_valid   <= '0;
         slot_rw      <= '0;
         slot_mr      <= '0;
         for (int unsigned k = 1; k <= NFWD; k++) begin
            slot_rd[k] <= '0;
         end
         ex_fwd_a_sel <= '0;
         ex_fwd_b_sel <= '0;
         stall_count  <= '0;
         flush_count  <= '0;
      end else begin
         for (int unsigned k = NFWD; k >= 2; k--) begin
            slot_valid[k] <= slot_valid[k-1];
            slot_rw[k]    <= slot_rw[k-1];
            slot_mr[k]    <= slot_mr[k-1];
            slot_rd[k]    <= slot_rd[k-1];
         end
         slot_valid[1] <= id_valid && !bubble_ex;
         slot_rw[1]    <= id_regwrite;
         slot_mr[1]    <= id_memread;
         slot_rd[1]    <= id_rd;

         if (bubble_ex) begin
            ex_fwd_a_sel <= '0;
            ex_fwd_b_sel <= '0;
         end else begin
            ex_fwd_a_sel <= prod_a;
            ex_fwd_b_sel <= prod_b;
         end

         if (ex_redirect) begin
            if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
         end else if (stall_raw) begin
            if (stall_count != '1) stall_count <= stall_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: a default instance and a CNT_W=4 instance share all
// inputs. Both are checked every cycle against an in-flight-instruction history model.
module tb_hazard_fwd_unit;

   localparam int unsigned REG_AW     = 5;
   localparam int unsigned NFWD       = 2;
   localparam int unsigned LOAD_STAGE = 2;
   localparam int unsigned SEL_W      = 2;

   logic clk = 1'b0;
   logic reset;
   logic id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, ex_redirect;
   logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;

   logic             stall_if, bubble_ex, flush_if_id;
   logic [SEL_W-1:0] ex_fwd_a_sel, ex_fwd_b_sel;
   logic [15:0]      stall_count, flush_count;

   logic             s_stall_if, s_bubble_ex, s_flush_if_id;
   logic [SEL_W-1:0] s_fwd_a_sel, s_fwd_b_sel;
   logic [3:0]       s_stall_count, s_flush_count;

   always #5 clk = ~clk;

   hazard_fwd_unit #(.REG_AW(REG_AW), .NFWD(NFWD), .LOAD_STAGE(LOAD_STAGE), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_redirect(ex_redirect),
      .stall_if(stall_if), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
      .ex_fwd_a_sel(ex_fwd_a_sel), .ex_fwd_b_sel(ex_fwd_b_sel),
      .stall_count(stall_count), .flush_count(flush_count));

   hazard_fwd_unit #(.REG_AW(REG_AW), .NFWD(NFWD), .LOAD_STAGE(LOAD_STAGE), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_redirect(ex_redirect),
      .stall_if(s_stall_if), .bubble_ex(s_bubble_ex), .flush_if_id(s_flush_if_id),
      .ex_fwd_a_sel(s_fwd_a_sel), .ex_fwd_b_sel(s_fwd_b_sel),
      .stall_count(s_stall_count), .flush_count(s_flush_count));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: hist[i] is the instruction that entered EX i+1 cycles ago
   typedef struct { bit v; bit [4:0] rd; bit rw; bit mr; } ent_t;
   ent_t hist[$];
   int   exp_sel_a, exp_sel_b;
   int   n_stall, n_flush;
   bit   last_stall;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int find_prod(input logic [4:0] rs, input logic use_rs);
      for (int j = 1; j <= NFWD; j++) begin
         if (id_valid && use_rs && rs != 0 && hist[j-1].v && hist[j-1].rw && hist[j-1].rd == rs)
            return j;
      end
      return 0;
   endfunction

   function automatic int sat(input int n, input int mx);
      return (n > mx) ? mx : n;
   endfunction

   function automatic void model_clear();
      ent_t e;
      e = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
      hist.delete();
      for (int i = 0; i < NFWD; i++) hist.push_back(e);
      exp_sel_a = 0;
      exp_sel_b = 0;
      n_stall   = 0;
      n_flush   = 0;
   endfunction

   // One clock: drive ID inputs, check at the falling edge, advance the model at the rising edge
   task automatic cycle(input bit v, input bit [4:0] r1, input bit [4:0] r2, input bit u1,
                        input bit u2, input bit [4:0] rd, input bit rw, input bit mr,
                        input bit rdr, input bit rst);
      int   pa, pb;
      bit   raw, e_stall, e_bub, e_flush;
      ent_t e;
      reset = rst; id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
      id_rd = rd; id_regwrite = rw; id_memread = mr; ex_redirect = rdr;
      @(negedge clk);
      pa  = find_prod(r1, u1);
      pb  = find_prod(r2, u2);
      raw = (pa > 0 && hist[pa-1].mr && pa < LOAD_STAGE) ||
            (pb > 0 && hist[pb-1].mr && pb < LOAD_STAGE);
      e_flush = !rst && rdr;
      e_bub   = !rst && (rdr || raw);
      e_stall = !rst && !rdr && raw;
      check_eq("stall_if",    stall_if,    e_stall);
      check_eq("bubble_ex",   bubble_ex,   e_bub);
      check_eq("flush_if_id", flush_if_id, e_flush);
      check_eq("sel_a",       ex_fwd_a_sel, exp_sel_a);
      check_eq("sel_b",       ex_fwd_b_sel, exp_sel_b);
      check_eq("stall_count", stall_count, sat(n_stall, 65535));
      check_eq("flush_count", flush_count, sat(n_flush, 65535));
      check_eq("sat_stall_if",    s_stall_if,    e_stall);
      check_eq("sat_sel_a",       s_fwd_a_sel,   exp_sel_a);
      check_eq("sat_sel_b",       s_fwd_b_sel,   exp_sel_b);
      check_eq("sat_stall_count", s_stall_count, sat(n_stall, 15));
      check_eq("sat_flush_count", s_flush_count, sat(n_flush, 15));
      @(posedge clk);
      if (rst) begin
         model_clear();
      end else begin
         e = '{v: v && !e_bub, rd: rd, rw: rw, mr: mr};
         hist.push_front(e);
         void'(hist.pop_back());
         exp_sel_a = e_bub ? 0 : pa;
         exp_sel_b = e_bub ? 0 : pb;
         if (rdr) n_flush++;
         else if (raw) n_stall++;
      end
      last_stall = e_stall;
      #1;
   endtask

   initial begin
      bit [4:0] r1, r2, rd;
      bit       v, u1, u2, rw, mr, rdr, rst;
      model_clear();
      last_stall = 1'b0;
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      check_eq("reset_sel_a", ex_fwd_a_sel, 0);
      check_eq("reset_stall_count", stall_count, 0);

      // addi x1,x0,5 ; add x2,x1,x1
      cycle(1, 0, 0, 1, 0, 1, 1, 0, 0, 0);
      cycle(1, 1, 1, 1, 1, 2, 1, 0, 0, 0);
      check_eq("t1_sel_a", ex_fwd_a_sel, 1);
      check_eq("t1_sel_b", ex_fwd_b_sel, 1);

      // lw x5,0(x0) ; add x6,x5,x0 (held one cycle by the stall)
      cycle(1, 0, 0, 1, 0, 5, 1, 1, 0, 0);
      cycle(1, 5, 0, 1, 1, 6, 1, 0, 0, 0);
      cycle(1, 5, 0, 1, 1, 6, 1, 0, 0, 0);
      check_eq("t2_sel_a", ex_fwd_a_sel, 2);
      check_eq("t2_sel_b", ex_fwd_b_sel, 0);
      check_eq("t2_stall_count", stall_count, 1);

      // addi x3 ; addi x3 ; sub x4,x3,x3
      cycle(1, 0, 0, 1, 0, 3, 1, 0, 0, 0);
      cycle(1, 0, 0, 1, 0, 3, 1, 0, 0, 0);
      cycle(1, 3, 3, 1, 1, 4, 1, 0, 0, 0);
      check_eq("t3_sel_a", ex_fwd_a_sel, 1);
      check_eq("t3_sel_b", ex_fwd_b_sel, 1);

      // addi x0,x0,1 ; add x7,x0,x0 ; lw x5 ; sw without rs2 use
      cycle(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      cycle(1, 0, 0, 1, 1, 7, 1, 0, 0, 0);
      check_eq("t4_sel_a", ex_fwd_a_sel, 0);
      check_eq("t4_sel_b", ex_fwd_b_sel, 0);
      cycle(1, 0, 0, 1, 0, 5, 1, 1, 0, 0);
      cycle(1, 0, 5, 1, 0, 0, 0, 0, 0, 0);
      check_eq("t4_stall_count", stall_count, 1);

      // Load-use hazard coincident with a redirect
      cycle(1, 0, 0, 1, 0, 8, 1, 1, 0, 0);
      cycle(1, 8, 0, 1, 1, 9, 1, 0, 1, 0);
      check_eq("t5_flush_count", flush_count, 1);
      check_eq("t5_stall_count", stall_count, 1);

      // 20 redirects saturate the 4-bit counter, then a single reset cycle
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++)
         cycle(1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1, 1,
               5'($urandom_range(0, 3)), 1, 1'($urandom), 1, 0);
      check_eq("t6_sat_flush", s_flush_count, 15);
      check_eq("t6_full_flush", flush_count, 20);
      cycle(1, 0, 0, 1, 0, 5, 1, 1, 0, 0);
      cycle(1, 5, 0, 1, 0, 6, 1, 0, 0, 1);
      check_eq("t6_rst_flush", s_flush_count, 0);
      check_eq("t6_rst_sel_a", ex_fwd_a_sel, 0);

      // Random traffic over a small register set to provoke frequent hazards
      r1 = 0; r2 = 0; rd = 0; v = 0; u1 = 0; u2 = 0; rw = 0; mr = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!last_stall) begin
            v  = ($urandom_range(0, 9) < 8);
            r1 = 5'($urandom_range(0, 3));
            r2 = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 3));
            u1 = 1'($urandom);
            u2 = 1'($urandom);
            rw = ($urandom_range(0, 9) < 8);
            mr = ($urandom_range(0, 9) < 3);
         end
         rdr = ($urandom_range(0, 99) < 8);
         rst = ($urandom_range(0, 99) < 1);
         cycle(v, r1, r2, u1, u2, rd, rw, mr, rdr, rst);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
